instruction_fetch: RTL and testbench

//   IF stage of the pipelined CPU, directly upstream of datamemory's instruction port.

---
 rtl/instruction_fetch.sv | 98 +++++++++
 tb/tb_instruction_fetch.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, drives the instruction-memory address and captures the
// returned word into the IF/ID pipeline register, honouring stall, flush and redirect.
module instruction_fetch #(
    parameter int unsigned              addresswidth = 32,
    parameter int unsigned              width        = 32,
    parameter logic [addresswidth-1:0]  RESET_PC     = '0,
    parameter logic [width-1:0]         NOP          = '0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    output logic [addresswidth-1:0] instrAddr,
    input  logic [width-1:0]        instrIn,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    redirect,
    input  logic [addresswidth-1:0] redirectAddr,
    output logic [width-1:0]        id_instr,
    output logic [addresswidth-1:0] id_pc,
    output logic [addresswidth-1:0] id_pcPlus4,
    output logic                    id_valid,
    output logic [31:0]             fetchCount,
    output logic                    misaligned
);

    localparam logic [addresswidth-1:0] PC_STEP = addresswidth'(4);

    logic [addresswidth-1:0] r_pc;
    logic [width-1:0]        r_id_instr;
    logic [addresswidth-1:0] r_id_pc;
    logic [addresswidth-1:0] r_id_pc_plus4;
    logic                    r_id_valid;
    logic [31:0]             r_fetch_count;
    logic                    r_misaligned;

    logic [addresswidth-1:0] w_pc_plus4;
    logic [addresswidth-1:0] w_redirect_pc;
    logic                    w_bubble;
    logic                    w_capture;

    // Word-aligned targets keep pc[1:0] at zero; the dropped bits only feed the sticky flag.
    assign w_pc_plus4    = r_pc + PC_STEP;
    assign w_redirect_pc = {redirectAddr[addresswidth-1:2], 2'b00};
    assign w_bubble      = redirect | flush;
    assign w_capture     = ~w_bubble & ~stall;

    // NOTE: reset is synchronous (sampled only at the clock edge), and all state
    // uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pc <= {RESET_PC[addresswidth-1:2], 2'b00};
        end else if (redirect) begin
            r_pc <= w_redirect_pc;
        end else if (!stall) begin
            r_pc <= w_pc_plus4;
        end
    end

    // IF/ID register: a bubble keeps the old pc fields, only instr/valid are cleared.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_id_instr    <= NOP;
            r_id_pc       <= '0;
            r_id_pc_plus4 <= '0;
            r_id_valid    <= 1'b0;
        end else if (w_bubble) begin
            r_id_instr    <= NOP;
            r_id_valid    <= 1'b0;
        end else if (w_capture) begin
            r_id_instr    <= instrIn;
            r_id_pc       <= r_pc;
            r_id_pc_plus4 <= w_pc_plus4;
            r_id_valid    <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_fetch_count <= '0;
            r_misaligned  <= 1'b0;
        end else begin
            if (w_capture) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (redirect && (redirectAddr[1:0] != 2'b00)) begin
                r_misaligned <= 1'b1;
            end
        end
    end

    assign instrAddr  = r_pc;
    assign id_instr   = r_id_instr;
    assign id_pc      = r_id_pc;
    assign id_pcPlus4 = r_id_pc_plus4;
    assign id_valid   = r_id_valid;
    assign fetchCount = r_fetch_count;
    assign misaligned = r_misaligned;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: per-edge vectors carry hand-computed
// expectations into a scoreboard queue that a negedge monitor drains and compares.
module tb_instruction_fetch;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        flush;
        logic        redir;
        logic [31:0] raddr;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic [31:0] exp_id_pc;
        logic [31:0] exp_pp4;
        logic        exp_valid;
        logic [31:0] exp_cnt;
        logic        exp_mis;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] instrAddr;
    logic [31:0] instrIn;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirectAddr;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pcPlus4;
    logic        id_valid;
    logic [31:0] fetchCount;
    logic        misaligned;

    vec_t vecs[$];
    vec_t sb_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   popped    = 0;

    always #5 clk = ~clk;

    // Instruction memory: word i holds 0x100+i.
    assign instrIn = 32'h100 + {2'b00, instrAddr[31:2]};

    instruction_fetch dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .instrAddr    (instrAddr),
        .instrIn      (instrIn),
        .stall        (stall),
        .flush        (flush),
        .redirect     (redirect),
        .redirectAddr (redirectAddr),
        .id_instr     (id_instr),
        .id_pc        (id_pc),
        .id_pcPlus4   (id_pcPlus4),
        .id_valid     (id_valid),
        .fetchCount   (fetchCount),
        .misaligned   (misaligned)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic add(input logic rst_n, input logic st, input logic fl, input logic rd,
                       input logic [31:0] ra, input logic [31:0] pc, input logic [31:0] ins,
                       input logic [31:0] ipc, input logic [31:0] pp4, input logic v,
                       input logic [31:0] cnt, input logic mis);
        vec_t t;
        t = '{rst_n, st, fl, rd, ra, pc, ins, ipc, pp4, v, cnt, mis};
        vecs.push_back(t);
    endtask

    // Monitor: compares one expected snapshot per edge, half a cycle after it.
    initial begin
        vec_t e;
        string s;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                s = $sformatf("e%0d", popped);
                check({s, " instrAddr"},  instrAddr,          e.exp_pc);
                check({s, " id_instr"},   id_instr,           e.exp_instr);
                check({s, " id_pc"},      id_pc,              e.exp_id_pc);
                check({s, " id_pcPlus4"}, id_pcPlus4,         e.exp_pp4);
                check({s, " id_valid"},   {31'd0, id_valid},  {31'd0, e.exp_valid});
                check({s, " fetchCount"}, fetchCount,         e.exp_cnt);
                check({s, " misaligned"}, {31'd0, misaligned}, {31'd0, e.exp_mis});
                popped++;
            end
        end
    end

    initial begin
        //   rst st fl rd raddr          pc            instr         id_pc         pp4           v  cnt mis
        // reset and four free-running fetches
        add(0, 0, 0, 0, 32'h0,         32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0);
        add(1, 0, 0, 0, 32'h0,         32'h4,        32'h100,      32'h0,        32'h4,        1, 1, 0);
        add(1, 0, 0, 0, 32'h0,         32'h8,        32'h101,      32'h4,        32'h8,        1, 2, 0);
        add(1, 0, 0, 0, 32'h0,         32'hC,        32'h102,      32'h8,        32'hC,        1, 3, 0);
        add(1, 0, 0, 0, 32'h0,         32'h10,       32'h103,      32'hC,        32'h10,       1, 4, 0);
        // re-reset, run to pc=8, stall three cycles, resume
        add(0, 0, 0, 0, 32'h0,         32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0);
        add(1, 0, 0, 0, 32'h0,         32'h4,        32'h100,      32'h0,        32'h4,        1, 1, 0);
        add(1, 0, 0, 0, 32'h0,         32'h8,        32'h101,      32'h4,        32'h8,        1, 2, 0);
        add(1, 1, 0, 0, 32'h0,         32'h8,        32'h101,      32'h4,        32'h8,        1, 2, 0);
        add(1, 1, 0, 0, 32'h0,         32'h8,        32'h101,      32'h4,        32'h8,        1, 2, 0);
        add(1, 1, 0, 0, 32'h0,         32'h8,        32'h101,      32'h4,        32'h8,        1, 2, 0);
        add(1, 0, 0, 0, 32'h0,         32'hC,        32'h102,      32'h8,        32'hC,        1, 3, 0);
        add(1, 0, 0, 0, 32'h0,         32'h10,       32'h103,      32'hC,        32'h10,       1, 4, 0);
        // redirect wins over stall
        add(1, 1, 0, 1, 32'h40,        32'h40,       32'h0,        32'hC,        32'h10,       0, 4, 0);
        add(1, 0, 0, 0, 32'h0,         32'h44,       32'h110,      32'h40,       32'h44,       1, 5, 0);
        // misaligned redirect target is aligned and flagged sticky
        add(1, 0, 0, 1, 32'h43,        32'h40,       32'h0,        32'h40,       32'h44,       0, 5, 1);
        add(1, 0, 0, 0, 32'h0,         32'h44,       32'h110,      32'h40,       32'h44,       1, 6, 1);
        // flush alone advances pc; flush with stall holds pc
        add(1, 0, 1, 0, 32'h0,         32'h48,       32'h0,        32'h40,       32'h44,       0, 6, 1);
        add(1, 0, 0, 0, 32'h0,         32'h4C,       32'h112,      32'h48,       32'h4C,       1, 7, 1);
        add(1, 1, 1, 0, 32'h0,         32'h4C,       32'h0,        32'h48,       32'h4C,       0, 7, 1);
        // pc wrap at top of address space
        add(1, 0, 0, 1, 32'hFFFFFFFC,  32'hFFFFFFFC, 32'h0,        32'h48,       32'h4C,       0, 7, 1);
        add(1, 0, 0, 0, 32'h0,         32'h0,        32'h400000FF, 32'hFFFFFFFC, 32'h0,        1, 8, 1);
        add(1, 0, 0, 0, 32'h0,         32'h4,        32'h100,      32'h0,        32'h4,        1, 9, 1);
        // reset overrides flush, redirect and stall
        add(0, 1, 1, 1, 32'h43,        32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0);
        add(1, 0, 0, 0, 32'h0,         32'h4,        32'h100,      32'h0,        32'h4,        1, 1, 0);
        add(1, 0, 0, 0, 32'h0,         32'h8,        32'h101,      32'h4,        32'h8,        1, 2, 0);

        foreach (vecs[i]) begin
            reset_n      = vecs[i].rst_n;
            stall        = vecs[i].stall;
            flush        = vecs[i].flush;
            redirect     = vecs[i].redir;
            redirectAddr = vecs[i].raddr;
            @(posedge clk);
            sb_q.push_back(vecs[i]);
            #1;
        end
        reset_n      = 1'b1;
        stall        = 1'b1;
        flush        = 1'b0;
        redirect     = 1'b0;
        redirectAddr = 32'h0;

        repeat (4) @(negedge clk);
        #1;
        check("scoreboard drained", popped, vecs.size());
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
